// File: rtl/debug_frame_tx_if.sv
// Trigger/snapshot/serial-line bundle between the CPU debug outputs and the frame serializer.
// The master drives trigger and debug bytes; the slave returns the TX line and frame status.
interface debug_frame_tx_if #(
  parameter int NUM_PORTS = 7
);
  logic                   trigger;
  logic [8*NUM_PORTS-1:0] debug_in;
  logic                   tx;
  logic                   busy;
  logic                   done;

  modport master (output trigger, debug_in, input tx, busy, done);
  modport slave  (input trigger, debug_in, output tx, busy, done);
endinterface

// File: rtl/debug_frame_tx.sv
// Snapshots NUM_PORTS debug bytes on trigger and sends SYNC, data, checksum as 8N1 UART, LSB first.
// tx/busy/done are registered; triggers arriving while busy are dropped, not queued.
module debug_frame_tx #(
  parameter int         CLKS_PER_BIT = 16,
  parameter int         NUM_PORTS    = 7,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  debug_frame_tx_if.slave   bus
);

  localparam int BAUDW = $clog2(CLKS_PER_BIT);
  localparam int IDXW  = $clog2(NUM_PORTS + 2);
  localparam logic [BAUDW-1:0] BAUD_LAST = BAUDW'(CLKS_PER_BIT - 1);
  localparam logic [IDXW-1:0]  LAST_IDX  = IDXW'(NUM_PORTS + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e                 state_q, state_d;
  logic [BAUDW-1:0]       baud_q, baud_d;
  logic [2:0]             bit_q, bit_d;
  logic [IDXW-1:0]        idx_q, idx_d;
  logic [8*NUM_PORTS-1:0] snap_q, snap_d;
  logic [7:0]             csum_q, csum_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [7:0] sum_c;
  logic [7:0] cur_byte;
  logic [2:0] bit_nx;
  logic       bit_end;

  always_comb begin
    sum_c = 8'h00;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sum_c = sum_c + bus.debug_in[8*i +: 8];
    end
  end

  // Byte being shifted out: index 0 is sync, the last index is the checksum.
  always_comb begin
    cur_byte = SYNC_BYTE;
    if (idx_q == LAST_IDX) begin
      cur_byte = csum_q;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (idx_q == IDXW'(i + 1)) cur_byte = snap_q[8*i +: 8];
      end
    end
  end

  assign bit_end = (baud_q == BAUD_LAST);
  assign bit_nx  = bit_q + 3'd1;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    csum_d  = csum_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + BAUDW'(1);
    end

    // tx_d always carries the level for the next cycle, so the line changes only on bit boundaries.
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.trigger) begin
          snap_d  = bus.debug_in;
          csum_d  = sum_c;
          idx_d   = '0;
          bit_d   = '0;
          baud_d  = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_d   = '0;
          tx_d    = cur_byte[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d = bit_nx;
            tx_d  = cur_byte[bit_nx];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + IDXW'(1);
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      csum_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      csum_q  <= csum_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_debug_frame_tx.sv
// Directed bench for debug_frame_tx: records the line per cycle and decodes frames at bit centres.
module tb_debug_frame_tx;

  localparam int C  = 4;
  localparam int P  = 7;
  localparam int FR = (P + 2) * 10 * C;

  logic clk = 1'b0;
  logic reset;

  debug_frame_tx_if #(.NUM_PORTS(P)) bus ();

  debug_frame_tx #(
    .CLKS_PER_BIT(C),
    .NUM_PORTS   (P),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic tx_log   [0:799];
  logic busy_log [0:799];
  logic done_log [0:799];

  // Index 0 is the first negedge after the edge that accepted the trigger.
  task automatic record(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_log[i]   = bus.tx;
      busy_log[i] = bus.busy;
      done_log[i] = bus.done;
    end
  endtask

  task automatic decode(input int base, input int b, output logic [7:0] d, output bit ok);
    logic v;
    int   s;
    ok = 1'b1;
    d  = 8'h00;
    for (int k = 0; k < 10; k++) begin
      s = base + (b * 10 + k) * C;
      v = tx_log[s + C/2];
      for (int j = 0; j < C; j++) if (tx_log[s + j] !== v) ok = 1'b0;
      if (k == 0 && v !== 1'b0) ok = 1'b0;
      if (k == 9 && v !== 1'b1) ok = 1'b0;
      if (k >= 1 && k <= 8) d[k-1] = v;
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [8*P-1:0] data, input logic [7:0] csum, input int b);
    if (b == 0) return 8'hA5;
    if (b <= P) return data[8*(b-1) +: 8];
    return csum;
  endfunction

  function automatic int count_hi(input int which, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) begin
      if (which == 0 && busy_log[i] === 1'b1) n++;
      if (which == 1 && done_log[i] === 1'b1) n++;
    end
    return n;
  endfunction

  task automatic test_reset;
    bus.trigger  = 1'b0;
    bus.debug_in = '0;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: tx=%b busy=%b done=%b, want 1 0 0", bus.tx, bus.busy, bus.done);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        bad++;
        $display("FAIL idle_cycle%0d: tx=%b busy=%b done=%b, want 1 0 0", i, bus.tx, bus.busy, bus.done);
      end
    end
  endtask

  task automatic test_basic;
    logic [8*P-1:0] data = 56'h07060504030201;
    logic [7:0] d, e;
    bit ok;
    int nb, first_low;
    @(negedge clk);
    bus.debug_in = data;
    bus.trigger  = 1'b1;
    fork
      record(400);
      begin @(negedge clk); bus.trigger = 1'b0; end
    join
    for (int b = 0; b < P + 2; b++) begin
      decode(0, b, d, ok);
      e = exp_byte(data, 8'h1C, b);
      total++;
      if (d !== e || !ok) begin
        bad++;
        $display("FAIL basic_byte%0d: got %02h framing_ok=%0d, want %02h framing_ok=1", b, d, ok, e);
      end
    end
    nb = count_hi(0, 0, 399);
    first_low = 400;
    for (int i = 399; i >= 0; i--) if (busy_log[i] !== 1'b1) first_low = i;
    total++;
    if (nb != FR || first_low != FR) begin
      bad++;
      $display("FAIL basic_busy: high %0d cycles first low at %0d, want %0d contiguous", nb, first_low, FR);
    end
    total++;
    if (count_hi(1, 0, 399) != 1 || done_log[FR] !== 1'b1) begin
      bad++;
      $display("FAIL basic_done: pulses=%0d done@%0d=%b, want 1 pulse at that cycle", count_hi(1, 0, 399), FR, done_log[FR]);
    end
  endtask

  task automatic test_snapshot;
    logic [8*P-1:0] data = 56'h16151413121110;
    logic [7:0] d, e;
    bit ok;
    int idle_bad;
    @(negedge clk);
    bus.debug_in = data;
    bus.trigger  = 1'b1;
    fork
      record(400);
      begin
        @(negedge clk);
        bus.trigger = 1'b0;
        for (int k = 1; k < 340; k++) begin
          @(negedge clk);
          if (k % 37 == 0) begin
            bus.trigger  = 1'b1;
            bus.debug_in = 56'({$urandom(), $urandom()});
          end else begin
            bus.trigger = 1'b0;
          end
        end
        bus.trigger = 1'b0;
      end
    join
    for (int b = 0; b < P + 2; b++) begin
      decode(0, b, d, ok);
      e = exp_byte(data, 8'h85, b);
      total++;
      if (d !== e || !ok) begin
        bad++;
        $display("FAIL snap_byte%0d: got %02h framing_ok=%0d, want %02h framing_ok=1", b, d, ok, e);
      end
    end
    total++;
    if (count_hi(0, 0, FR - 1) != FR) begin
      bad++;
      $display("FAIL snap_busy: high %0d of first %0d cycles, want all", count_hi(0, 0, FR - 1), FR);
    end
    total++;
    if (count_hi(1, 0, 399) != 1 || done_log[FR] !== 1'b1) begin
      bad++;
      $display("FAIL snap_done: pulses=%0d done@%0d=%b, want 1 pulse there", count_hi(1, 0, 399), FR, done_log[FR]);
    end
    idle_bad = 0;
    for (int i = FR; i < 400; i++) if (tx_log[i] !== 1'b1 || busy_log[i] !== 1'b0) idle_bad++;
    total++;
    if (idle_bad != 0) begin
      bad++;
      $display("FAIL snap_no_second_frame: %0d non-idle cycles after done, want 0", idle_bad);
    end
  endtask

  task automatic test_back_to_back;
    logic [8*P-1:0] da = {P{8'hFF}};
    logic [8*P-1:0] db = '0;
    logic [7:0] d, e;
    bit ok;
    @(negedge clk);
    bus.debug_in = da;
    bus.trigger  = 1'b1;
    fork
      record(800);
      begin
        @(negedge clk);
        bus.debug_in = db;
        repeat (FR + 1) @(negedge clk);
        bus.trigger = 1'b0;
      end
    join
    for (int b = 0; b < P + 2; b++) begin
      decode(0, b, d, ok);
      e = exp_byte(da, 8'hF9, b);
      total++;
      if (d !== e || !ok) begin
        bad++;
        $display("FAIL b2b_a_byte%0d: got %02h framing_ok=%0d, want %02h framing_ok=1", b, d, ok, e);
      end
      decode(FR + 1, b, d, ok);
      e = exp_byte(db, 8'h00, b);
      total++;
      if (d !== e || !ok) begin
        bad++;
        $display("FAIL b2b_b_byte%0d: got %02h framing_ok=%0d, want %02h framing_ok=1", b, d, ok, e);
      end
    end
    total++;
    if (done_log[FR] !== 1'b1 || tx_log[FR + 1] !== 1'b0 || busy_log[FR + 1] !== 1'b1) begin
      bad++;
      $display("FAIL b2b_restart: done=%b next tx=%b busy=%b, want 1 0 1", done_log[FR], tx_log[FR + 1], busy_log[FR + 1]);
    end
    total++;
    if (count_hi(1, 0, 799) != 2 || done_log[2*FR + 1] !== 1'b1 || count_hi(0, 0, 799) != 2*FR) begin
      bad++;
      $display("FAIL b2b_counts: dones=%0d busy=%0d second done=%b, want 2 %0d 1",
               count_hi(1, 0, 799), count_hi(0, 0, 799), done_log[2*FR + 1], 2*FR);
    end
  endtask

  task automatic test_reset_mid;
    logic [8*P-1:0] data = 56'h7E81F00F965A3C;
    logic [7:0] d, e;
    bit ok;
    int dones, nonidle;
    @(negedge clk);
    bus.debug_in = 56'h07060504030201;
    bus.trigger  = 1'b1;
    for (int i = 0; i <= 130; i++) begin
      @(negedge clk);
      if (i == 0) bus.trigger = 1'b0;
    end
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_busy_before_reset: busy=%b, want 1", bus.busy);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_next: tx=%b busy=%b done=%b, want 1 0 0", bus.tx, bus.busy, bus.done);
    end
    reset = 1'b0;
    dones = 0;
    nonidle = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) nonidle++;
    end
    total++;
    if (dones != 0 || nonidle != 0) begin
      bad++;
      $display("FAIL mid_after_reset: dones=%0d nonidle=%0d, want 0 0", dones, nonidle);
    end
    bus.debug_in = data;
    bus.trigger  = 1'b1;
    fork
      record(400);
      begin @(negedge clk); bus.trigger = 1'b0; end
    join
    for (int b = 0; b < P + 2; b++) begin
      decode(0, b, d, ok);
      e = exp_byte(data, 8'h2A, b);
      total++;
      if (d !== e || !ok) begin
        bad++;
        $display("FAIL mid_retry_byte%0d: got %02h framing_ok=%0d, want %02h framing_ok=1", b, d, ok, e);
      end
    end
    total++;
    if (count_hi(1, 0, 399) != 1 || done_log[FR] !== 1'b1) begin
      bad++;
      $display("FAIL mid_retry_done: pulses=%0d done@%0d=%b, want 1 pulse there", count_hi(1, 0, 399), FR, done_log[FR]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_snapshot();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debug_frame_tx.md
Name: debug_frame_tx

Overview:
- Transmit-side serializer for the serial-port debug link.
- On a trigger, snapshots the CPU's debug bytes (debug_port1..debug_port7) and sends them as one framed UART packet (8N1, LSB first) to the host debugger.
- Frame: SYNC byte, NUM_PORTS data bytes, 8-bit checksum byte.
- Sits between the cpu top-level debug outputs and the board TX pin.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; legal range 2..65535.
- NUM_PORTS, 7, number of debug bytes per frame; legal range 1..15.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- trigger  input  1  request to snapshot and send one frame.
- debug_in  input  8*NUM_PORTS  debug bytes; [7:0]=debug_port1, [15:8]=debug_port2, and so on.
- tx  output  1  UART serial line; idle high.
- busy  output  1  high while a frame is in flight.
- done  output  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Reset (sampled at clk edge):
  - Next cycle: tx=1, busy=0, done=0, state=IDLE, all counters=0.
  - Reset mid-frame aborts the frame immediately; no partial byte is completed and no done pulse is produced.
  - Reset has priority over trigger.
- States: IDLE, START, DATA, STOP. All outputs are registered.
- IDLE:
  - tx=1.
  - trigger=1 at edge N: latch debug_in into an internal snapshot, compute checksum, byte_idx=0, state=START.
  - From cycle N+1: busy=1, tx=0.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
- DATA:
  - tx = current_byte[bit_idx], each bit held CLKS_PER_BIT cycles.
  - After bit 7 completes, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - Then, if byte_idx < NUM_PORTS+1: byte_idx++ and go to START.
  - Otherwise go to IDLE; busy=0 and done=1 for exactly one cycle, both starting the cycle after the final stop-bit period.
- Byte order by byte_idx:
  - 0 = SYNC_BYTE.
  - 1..NUM_PORTS = snapshot byte (idx-1), i.e. port1 first.
  - NUM_PORTS+1 = checksum.
- Checksum: sum of the NUM_PORTS snapshot bytes modulo 256. SYNC_BYTE is excluded; overflow wraps.
- Snapshot isolation: debug_in changes after acceptance never affect the frame in flight.
- Frame length: exactly (NUM_PORTS+2)*10*CLKS_PER_BIT cycles from the first tx=0 to the cycle done=1.
- Trigger handling:
  - Ignored while busy=1; it is not queued.
  - Trigger high in the cycle done=1 (state IDLE) is accepted, so back-to-back frames have no extra idle bits.
  - Trigger held high continuously yields back-to-back frames.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps.
  - Must be wide enough for CLKS_PER_BIT-1.
  - No glitches on tx between bit boundaries.

Test Plan:
- Reset, then 20 idle cycles with no trigger -> tx=1, busy=0, done=0 throughout.
- CLKS_PER_BIT=4, debug_in bytes 01..07, trigger one cycle -> tx decodes to A5,01,02,03,04,05,06,07,1C:
  - busy high for exactly 360 cycles.
  - single done pulse.
  - every start bit 0, every stop bit 1.
- All bytes FF -> checksum byte F9 (1785 mod 256). All bytes 00 -> checksum 00.
- Change debug_in and pulse trigger repeatedly mid-frame -> transmitted frame matches the original snapshot, no second frame starts, and busy stays continuous.
- Hold trigger high for two frames with different debug_in -> second start bit begins the cycle after the first done; the second frame carries the new values.
- Assert reset during DATA of byte 3 -> tx=1 and busy=0 the next cycle, no done pulse, and a following trigger sends a complete correct frame.
